mvau_inp_buf_ctrl: RTL

MVAU_INP_BUF_CTRL -- requirements
Module: mvau_inp_buf_ctrl

---
 rtl/mvau_inp_buf_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mvau_inp_buf_ctrl.sv
// mvau_inp_buf_ctrl
// Address/handshake controller for the MVAU input-vector buffer.
// Pass 0 of every vector streams words from upstream into the buffer
// (WRITE); passes 1..NF-1 replay the stored words (READ).
// out_v/out_last are registered strobes aligned with the buffer's
// registered read / write-through output.
//
// Handshake: upstream word moves when in_v && in_rdy; a word is issued
// to the buffer on any cycle with wr_en || rd_en, which can only happen
// with out_rdy=1. out_v is a one-cycle strobe, never held.
//
// Optional feature: define MVAU_INP_BUF_VEC_CNT_EN to enable the
// completed-vector counter on vec_cnt; otherwise vec_cnt is tied to 0.
// state_dbg exposes the FSM state (0 = WRITE, 1 = READ).
module mvau_inp_buf_ctrl #(
    parameter int SF       = 16,
    parameter int NF       = 4,
    parameter int BUF_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_v,
    output logic                in_rdy,
    input  logic                out_rdy,
    output logic                wr_en,
    output logic                rd_en,
    output logic [BUF_ADDR-1:0] addr,
    output logic                out_v,
    output logic                out_last,
    output logic [15:0]         vec_cnt,
    output logic                state_dbg
);

    localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [BUF_ADDR-1:0] SF_LAST = BUF_ADDR'(SF - 1);
    localparam logic [NF_W-1:0]     NF_LAST = NF_W'(NF - 1);

    typedef enum logic {
        S_WRITE = 1'b0,
        S_READ  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [BUF_ADDR-1:0] sf_cnt, sf_cnt_nxt;
    logic [NF_W-1:0]     nf_cnt, nf_cnt_nxt;
    logic                issue;
    logic                sf_wrap;

    // Next-state, counter update and handshake outputs; all strobes are
    // gated off while reset is asserted.
    always_comb begin
        state_nxt  = state;
        sf_cnt_nxt = sf_cnt;
        nf_cnt_nxt = nf_cnt;
        in_rdy     = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        issue      = 1'b0;
        sf_wrap    = 1'b0;
        if (rst_n) begin
            case (state)
                S_WRITE: begin
                    in_rdy = out_rdy;
                    wr_en  = in_v && out_rdy;
                end
                S_READ: begin
                    rd_en = out_rdy;
                end
                default: ;
            endcase
        end
        issue   = wr_en || rd_en;
        sf_wrap = issue && (sf_cnt == SF_LAST);
        if (issue) begin
            sf_cnt_nxt = sf_wrap ? '0 : sf_cnt + 1'b1;
        end
        if (sf_wrap) begin
            case (state)
                S_WRITE: begin
                    if (NF > 1) begin
                        state_nxt  = S_READ;
                        nf_cnt_nxt = NF_W'(1);
                    end else begin
                        nf_cnt_nxt = '0;
                    end
                end
                S_READ: begin
                    if (nf_cnt == NF_LAST) begin
                        state_nxt  = S_WRITE;
                        nf_cnt_nxt = '0;
                    end else begin
                        nf_cnt_nxt = nf_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters and the registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WRITE;
            sf_cnt   <= '0;
            nf_cnt   <= '0;
            out_v    <= 1'b0;
            out_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            sf_cnt   <= sf_cnt_nxt;
            nf_cnt   <= nf_cnt_nxt;
            out_v    <= issue;
            out_last <= sf_wrap;
        end
    end

    assign addr      = sf_cnt;
    assign state_dbg = (state == S_READ);

`ifdef MVAU_INP_BUF_VEC_CNT_EN
    logic vec_done;

    // A vector completes on the wrap of its final pass.
    assign vec_done = sf_wrap &&
                      ((state == S_READ) ? (nf_cnt == NF_LAST) : (NF == 1));

    // Completed-vector counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt <= '0;
        end else if (vec_done) begin
            vec_cnt <= vec_cnt + 16'd1;
        end
    end
`else
    assign vec_cnt = '0;
`endif

endmodule
